// File: rtl/fft_frame_collector.sv
// Ping-pong frame collector: gathers a serial stream of WIDTH-bit samples into
// SAMPLES-entry frames and presents each completed frame as a parallel array.
// One bank fills while the other is held stable for the downstream FFT stage.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   sample_in      incoming sample, index order = arrival order
//   sample_valid   sample_in is valid this cycle
//   sample_ready   collector accepts a sample this cycle (combinational from state)
//   frame_out      held frame, element 0 is the earliest sample
//   frame_valid    frame_out holds a complete frame
//   frame_ready    consumer takes the frame this cycle
//   dropped_count  saturating count of offered-but-refused samples
module fft_frame_collector #(
  parameter int unsigned SAMPLES = 8,
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned DROP_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [WIDTH-1:0]  frame_out [SAMPLES-1:0],
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [DROP_W-1:0] dropped_count
);

  localparam int unsigned      IDX_W    = (SAMPLES > 2) ? $clog2(SAMPLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic [WIDTH-1:0] bank [2][SAMPLES];
  logic [1:0]       bank_full;
  logic [1:0]       bank_full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;

  logic sample_fire;
  logic frame_fire;
  logic frame_done;

  // Handshake decode; ready only depends on registered state and reset.
  assign sample_ready = !reset && !bank_full[wr_bank];
  assign sample_fire  = sample_valid && sample_ready;
  assign frame_valid  = bank_full[rd_bank];
  assign frame_fire   = frame_valid && frame_ready;
  assign frame_done   = sample_fire && (wr_idx == LAST_IDX);

  // Completion and release always target different banks, so both may apply.
  always_comb begin
    bank_full_nxt = bank_full;
    if (frame_fire) bank_full_nxt[rd_bank] = 1'b0;
    if (frame_done) bank_full_nxt[wr_bank] = 1'b1;
  end

  // Output frame is a straight register read of the read bank.
  for (genvar g = 0; g < SAMPLES; g++) begin : g_frame_out
    assign frame_out[g] = bank[rd_bank][g];
  end

  // Bank storage, pointers and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SAMPLES; i++) begin
          bank[b][i] <= '0;
        end
      end
      bank_full     <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_idx        <= '0;
      dropped_count <= '0;
    end else begin
      bank_full <= bank_full_nxt;

      if (sample_fire) begin
        bank[wr_bank][wr_idx] <= sample_in;
        if (wr_idx == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end

      if (frame_fire) begin
        rd_bank <= !rd_bank;
      end

      if (sample_valid && !sample_ready && (dropped_count != DROP_MAX)) begin
        dropped_count <= dropped_count + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Self-checking bench for fft_frame_collector: a directed vector table for the
// fill / full / release sequence, hand-written multi-cycle corner cases, and a
// randomized run compared each cycle against a queue-based frame model.
module tb_fft_frame_collector;

  localparam int unsigned SAMPLES = 8;
  localparam int unsigned WIDTH   = 3;
  localparam int unsigned DROP_W  = 8;
  localparam int unsigned FW      = SAMPLES * WIDTH;
  localparam int          DROP_SAT = (1 << DROP_W) - 1;

  typedef logic [FW-1:0] frame_t;

  typedef struct {
    logic              rst;
    logic              sv;
    logic [WIDTH-1:0]  sin;
    logic              fr;
    logic              exp_ready;
    logic              exp_valid;
    logic [DROP_W-1:0] exp_drop;
    logic              chk_frame;
    frame_t            exp_frame;
  } vec_t;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic [WIDTH-1:0]  frame_out [SAMPLES-1:0];
  logic              frame_valid;
  logic              frame_ready;
  logic [DROP_W-1:0] dropped_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: queue of complete frames waiting for the consumer
  // (at most two can be held), samples of the frame being collected, drops.
  frame_t           held[$];
  logic [WIDTH-1:0] partial[$];
  int               m_drop  = 0;
  bit               m_known = 0;

  fft_frame_collector #(
    .SAMPLES(SAMPLES),
    .WIDTH  (WIDTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_out    (frame_out),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .dropped_count(dropped_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = !clk;
  end

  function automatic frame_t pack_dut();
    frame_t f;
    for (int i = 0; i < SAMPLES; i++) f[i*WIDTH +: WIDTH] = frame_out[i];
    return f;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    if (!m_known) return;
    cmp("model_ready", 64'(sample_ready), 64'(!reset && (held.size() < 2)));
    cmp("model_valid", 64'(frame_valid), 64'(held.size() > 0));
    if (held.size() > 0) cmp("model_frame", 64'(pack_dut()), 64'(held[0]));
    cmp("model_drop", 64'(dropped_count), 64'(m_drop));
  endtask

  task automatic model_step(input logic rst, input logic sv, input logic [WIDTH-1:0] sin,
                            input logic fr);
    bit     rdy;
    bit     vld;
    frame_t f;
    if (rst) begin
      held.delete();
      partial.delete();
      m_drop  = 0;
      m_known = 1;
    end else begin
      rdy = (held.size() < 2);
      vld = (held.size() > 0);
      if (sv && !rdy && (m_drop < DROP_SAT)) m_drop++;
      if (vld && fr) void'(held.pop_front());
      if (sv && rdy) begin
        partial.push_back(sin);
        if (partial.size() == SAMPLES) begin
          for (int i = 0; i < SAMPLES; i++) f[i*WIDTH +: WIDTH] = partial[i];
          held.push_back(f);
          partial.delete();
        end
      end
    end
  endtask

  // One clock cycle: drive, let combinational outputs settle, check, advance.
  task automatic cyc(input logic rst, input logic sv, input logic [WIDTH-1:0] sin,
                     input logic fr);
    reset        = rst;
    sample_valid = sv;
    sample_in    = sin;
    frame_ready  = fr;
    #2;
    check_model();
    model_step(rst, sv, sin, fr);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int row);
    reset        = v.rst;
    sample_valid = v.sv;
    sample_in    = v.sin;
    frame_ready  = v.fr;
    #2;
    cmp($sformatf("vec%0d_ready", row), 64'(sample_ready), 64'(v.exp_ready));
    cmp($sformatf("vec%0d_valid", row), 64'(frame_valid), 64'(v.exp_valid));
    cmp($sformatf("vec%0d_drop", row), 64'(dropped_count), 64'(v.exp_drop));
    if (v.chk_frame) cmp($sformatf("vec%0d_frame", row), 64'(pack_dut()), 64'(v.exp_frame));
    check_model();
    model_step(v.rst, v.sv, v.sin, v.fr);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic sv, input int sin, input logic fr,
                              input logic er, input logic ev, input int ed,
                              input logic cf, input frame_t ef);
    vec_t v;
    v.rst = rst; v.sv = sv; v.sin = WIDTH'(sin); v.fr = fr;
    v.exp_ready = er; v.exp_valid = ev; v.exp_drop = DROP_W'(ed);
    v.chk_frame = cf; v.exp_frame = ef;
    return v;
  endfunction

  initial begin
    vec_t   tbl[$];
    frame_t f_up;
    frame_t f_dn;
    frame_t f_exp;
    int     nvalid;
    logic   r_rst;
    logic   r_sv;
    logic   r_fr;

    for (int i = 0; i < SAMPLES; i++) begin
      f_up[i*WIDTH +: WIDTH] = WIDTH'(i);
      f_dn[i*WIDTH +: WIDTH] = WIDTH'(SAMPLES - 1 - i);
    end

    // Fill bank 0 with 0..7, bank 1 with 7..0, overflow 5 times, release once.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, '0));
    for (int i = 0; i < SAMPLES; i++)
      tbl.push_back(mk(0, 1, i, 0, 1, 0, 0, (i == 0), '0));
    for (int j = 0; j < SAMPLES; j++)
      tbl.push_back(mk(0, 1, SAMPLES - 1 - j, 0, 1, 1, 0, 1, f_up));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 1, k + 1, 0, 0, 1, k, 1, f_up));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 5, 1, f_up));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 5, 1, f_dn));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 5, 1, f_dn));

    reset = 1'b1; sample_valid = 1'b0; sample_in = '0; frame_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int r = 0; r < tbl.size(); r++) apply_vec(tbl[r], r);

    // Continuous stream with consumer always ready: 3 one-cycle frames, no drops.
    cyc(1, 0, '0, 1);
    nvalid = 0;
    for (int i = 0; i < 3 * SAMPLES; i++) begin
      cyc(0, 1, WIDTH'($urandom), 1);
      if (frame_valid === 1'b1) nvalid++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, '0, 1);
      if (frame_valid === 1'b1) nvalid++;
    end
    cmp("stream_frame_cycles", 64'(nvalid), 64'd3);
    cmp("stream_drops", 64'(dropped_count), 64'd0);

    // Reset in the middle of a frame discards the partial data.
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, WIDTH'(5), 0);
    cyc(1, 1, WIDTH'(5), 0);
    cmp("midrst_frame_zero", 64'(pack_dut()), 64'd0);
    cmp("midrst_valid", 64'(frame_valid), 64'd0);
    cmp("midrst_drop", 64'(dropped_count), 64'd0);
    for (int i = 0; i < SAMPLES; i++) begin
      cyc(0, 1, WIDTH'(i + 2), 0);
      f_exp[i*WIDTH +: WIDTH] = WIDTH'(i + 2);
    end
    cmp("midrst_valid_after", 64'(frame_valid), 64'd1);
    cmp("midrst_frame", 64'(pack_dut()), 64'(f_exp));
    cmp("midrst_drop_after", 64'(dropped_count), 64'd0);

    // Both banks full for 300 offered samples: counter saturates, never wraps.
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 2 * SAMPLES; i++) cyc(0, 1, WIDTH'($urandom), 0);
    for (int i = 0; i < 300; i++) cyc(0, 1, WIDTH'($urandom), 0);
    cmp("sat_drop", 64'(dropped_count), 64'(DROP_SAT));
    cyc(0, 1, WIDTH'($urandom), 0);
    cmp("sat_drop_hold", 64'(dropped_count), 64'(DROP_SAT));
    cmp("sat_ready", 64'(sample_ready), 64'd0);

    // Randomized traffic with occasional resets against the frame model.
    cyc(1, 0, '0, 0);
    for (int i = 0; i < 1500; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_sv  = ($urandom_range(0, 3) != 0);
      r_fr  = ($urandom_range(0, 2) != 0);
      cyc(r_rst, r_sv, WIDTH'($urandom), r_fr);
    end
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
